// File: rtl/gfx_fragment_fifo.sv
// rtl/gfx_fragment_fifo.sv - elastic fragment queue between rasterizer and pixel renderer
module gfx_fragment_fifo #(
    parameter int point_width     = 16,
    parameter int fifo_depth_log2 = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [point_width-1:0]     target_size_x_i,
    input  logic [point_width-1:0]     target_size_y_i,
    input  logic                       clip_enable_i,
    input  logic [point_width-1:0]     pixel_x_i,
    input  logic [point_width-1:0]     pixel_y_i,
    input  logic [point_width-1:0]     pixel_z_i,
    input  logic                       zbuffer_enable_i,
    input  logic [31:0]                color_i,
    input  logic                       write_i,
    output logic                       ack_o,
    output logic [point_width-1:0]     pixel_x_o,
    output logic [point_width-1:0]     pixel_y_o,
    output logic [point_width-1:0]     pixel_z_o,
    output logic                       zbuffer_enable_o,
    output logic [31:0]                color_o,
    output logic                       write_o,
    input  logic                       ack_i,
    output logic                       full_o,
    output logic [fifo_depth_log2:0]   count_o,
    output logic                       busy_o
);

    localparam int DEPTH   = 1 << fifo_depth_log2;
    localparam int ENTRY_W = 3 * point_width + 1 + 32;
    localparam logic [fifo_depth_log2:0]   CNT_FULL = (fifo_depth_log2 + 1)'(DEPTH);
    localparam logic [fifo_depth_log2:0]   CNT_ONE  = (fifo_depth_log2 + 1)'(1);
    localparam logic [fifo_depth_log2-1:0] PTR_ONE  = fifo_depth_log2'(1);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t                     state_q, state_d;
    logic                       pending_q, pending_d;
    logic                       ack_q;
    logic                       write_o_q, write_o_d;
    logic [fifo_depth_log2-1:0] wptr_q, rptr_q;
    logic [fifo_depth_log2:0]   count_q, count_d;
    logic [ENTRY_W-1:0]         mem_q [0:DEPTH-1];
    logic [ENTRY_W-1:0]         head;
    logic [point_width-1:0]     x_q, y_q, z_q;
    logic                       zen_q;
    logic [31:0]                color_q;
    logic                       full, accept, clipped, push, pop;

    // Full is taken from the registered count, so a same-edge pop never frees a slot early.
    assign full    = (count_q == CNT_FULL);
    assign accept  = (write_i | pending_q) & ~full;
    assign clipped = clip_enable_i &
                     ((pixel_x_i >= target_size_x_i) | (pixel_y_i >= target_size_y_i));
    assign push    = accept & ~clipped;
    assign head    = mem_q[rptr_q];

    always_comb begin
        pending_d = pending_q;
        if (accept)
            pending_d = 1'b0;
        else if (write_i)
            pending_d = 1'b1;
    end

    always_comb begin
        state_d   = state_q;
        write_o_d = 1'b0;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    write_o_d = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (ack_i)
                    state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem_q[wptr_q] <= {pixel_x_i, pixel_y_i, pixel_z_i, zbuffer_enable_i, color_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
            write_o_q <= 1'b0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            z_q       <= '0;
            zen_q     <= 1'b0;
            color_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ack_q     <= accept;
            write_o_q <= write_o_d;
            count_q   <= count_d;
            if (push)
                wptr_q <= wptr_q + PTR_ONE;
            if (pop) begin
                rptr_q <= rptr_q + PTR_ONE;
                {x_q, y_q, z_q, zen_q, color_q} <= head;
            end
        end
    end

    assign ack_o            = ack_q;
    assign write_o          = write_o_q;
    assign pixel_x_o        = x_q;
    assign pixel_y_o        = y_q;
    assign pixel_z_o        = z_q;
    assign zbuffer_enable_o = zen_q;
    assign color_o          = color_q;
    assign full_o           = full;
    assign count_o          = count_q;
    assign busy_o           = pending_q | (count_q != '0) | (state_q == ST_WAIT);

endmodule

// File: tb/tb_gfx_fragment_fifo.sv
// tb/tb_gfx_fragment_fifo.sv - directed self-checking bench for gfx_fragment_fifo
module tb_gfx_fragment_fifo;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [15:0] target_size_x_i, target_size_y_i;
    logic        clip_enable_i;
    logic [15:0] pixel_x_i, pixel_y_i, pixel_z_i;
    logic        zbuffer_enable_i;
    logic [31:0] color_i;
    logic        write_i;
    logic        ack_o;
    logic [15:0] pixel_x_o, pixel_y_o, pixel_z_o;
    logic        zbuffer_enable_o;
    logic [31:0] color_o;
    logic        write_o;
    logic        ack_i;
    logic        full_o;
    logic [3:0]  count_o;
    logic        busy_o;

    logic        ack_man;
    logic        ack_auto;
    logic        auto_ack;
    assign ack_i = ack_man | ack_auto;

    always #5 clk_i = ~clk_i;

    gfx_fragment_fifo #(.point_width(16), .fifo_depth_log2(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .target_size_x_i(target_size_x_i), .target_size_y_i(target_size_y_i),
        .clip_enable_i(clip_enable_i),
        .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i), .pixel_z_i(pixel_z_i),
        .zbuffer_enable_i(zbuffer_enable_i), .color_i(color_i), .write_i(write_i),
        .ack_o(ack_o),
        .pixel_x_o(pixel_x_o), .pixel_y_o(pixel_y_o), .pixel_z_o(pixel_z_o),
        .zbuffer_enable_o(zbuffer_enable_o), .color_o(color_o), .write_o(write_o),
        .ack_i(ack_i), .full_o(full_o), .count_o(count_o), .busy_o(busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Renderer-side log of every write_o pulse, plus an ack_o pulse counter.
    logic [15:0] ev_x [$];
    logic [31:0] ev_c [$];
    int          ack_seen = 0;

    always @(negedge clk_i) begin
        if (write_o) begin
            ev_x.push_back(pixel_x_o);
            ev_c.push_back(color_o);
        end
        if (ack_o)
            ack_seen++;
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        int lat;
        ack_auto = 1'b0;
        forever begin
            step();
            if (auto_ack && write_o) begin
                lat = $urandom_range(1, 5);
                repeat (lat) @(posedge clk_i);
                #1 ack_auto = 1'b1;
                step();
                ack_auto = 1'b0;
            end
        end
    end

    task automatic send_frag(input logic [15:0] x, input logic [15:0] y,
                             input logic [31:0] c, output int waited);
        pixel_x_i        = x;
        pixel_y_i        = y;
        pixel_z_i        = x + 16'd7;
        zbuffer_enable_i = x[0];
        color_i          = c;
        write_i          = 1'b1;
        step();
        write_i = 1'b0;
        waited  = 0;
        while (!ack_o && waited < 50) begin
            step();
            waited++;
        end
    endtask

    task automatic ack_pulse();
        ack_man = 1'b1;
        step();
        ack_man = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (busy_o && n < budget) begin
            step();
            n++;
        end
        check(tag, busy_o, 1'b0);
    endtask

    initial begin
        int w;
        int base;
        int acks0;
        int late;

        rst_i = 1'b1; write_i = 1'b0; ack_man = 1'b0; auto_ack = 1'b0;
        target_size_x_i = 16'd640; target_size_y_i = 16'd480; clip_enable_i = 1'b1;
        pixel_x_i = '0; pixel_y_i = '0; pixel_z_i = '0; zbuffer_enable_i = 1'b0; color_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ack", ack_o, 0);
        check("rst_write", write_o, 0);
        check("rst_count", count_o, 0);
        check("rst_full", full_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_x", pixel_x_o, 0);
        check("rst_color", color_o, 0);
        rst_i = 1'b0;
        step();

        // T1 single fragment latency and field pass-through
        pixel_z_i = 16'h0010;
        pixel_x_i = 16'd3; pixel_y_i = 16'd2; color_i = 32'hFF00FF00; zbuffer_enable_i = 1'b1;
        write_i = 1'b1;
        step();
        write_i = 1'b0;
        check("t1_ack", ack_o, 1);
        check("t1_count1", count_o, 1);
        check("t1_write_early", write_o, 0);
        step();
        check("t1_write", write_o, 1);
        check("t1_x", pixel_x_o, 16'd3);
        check("t1_y", pixel_y_o, 16'd2);
        check("t1_z", pixel_z_o, 16'h0010);
        check("t1_zen", zbuffer_enable_o, 1);
        check("t1_color", color_o, 32'hFF00FF00);
        check("t1_count0", count_o, 0);
        check("t1_ack_pulse", ack_o, 0);
        step();
        check("t1_write_pulse", write_o, 0);
        check("t1_busy_wait", busy_o, 1);
        ack_pulse();
        check("t1_busy_done", busy_o, 0);

        // T2 clipping, including the exact edges of the target
        base = ev_x.size();
        send_frag(16'd640, 16'd0, 32'h11111111, w);
        check("t2_clip_x_ack", w, 0);
        check("t2_clip_x_count", count_o, 0);
        send_frag(16'd0, 16'd480, 32'h22222222, w);
        check("t2_clip_y_ack", w, 0);
        repeat (4) step();
        check("t2_clip_nowrite", ev_x.size() - base, 0);
        check("t2_clip_busy", busy_o, 0);
        send_frag(16'd639, 16'd479, 32'h33333333, w);
        step();
        check("t2_edge_write", write_o, 1);
        check("t2_edge_x", pixel_x_o, 16'd639);
        ack_pulse();
        clip_enable_i = 1'b0;
        send_frag(16'd640, 16'd0, 32'h44444444, w);
        step();
        check("t2_noclip_write", write_o, 1);
        check("t2_noclip_x", pixel_x_o, 16'd640);
        ack_pulse();
        clip_enable_i = 1'b1;

        // T3 fill to full with the renderer stalled
        base  = ev_x.size();
        acks0 = ack_seen;
        late  = 0;
        for (int i = 0; i < 9; i++) begin
            send_frag(16'(100 + i), 16'd1, 32'hA0000000 + i, w);
            if (w != 0) late++;
        end
        check("t3_acks_prompt", late, 0);
        check("t3_count", count_o, 8);
        check("t3_full", full_o, 1);
        check("t3_one_issued", ev_x.size() - base, 1);
        pixel_x_i = 16'd109; color_i = 32'hA0000009; write_i = 1'b1;
        step();
        write_i = 1'b0;
        repeat (5) step();
        check("t3_tenth_held", ack_seen - acks0, 9);
        check("t3_count_held", count_o, 8);
        check("t3_busy", busy_o, 1);
        ack_pulse();
        check("t3_idle_write", write_o, 0);
        check("t3_idle_ack", ack_o, 0);
        step();
        check("t3_next_write", write_o, 1);
        check("t3_next_x", pixel_x_o, 16'd101);
        check("t3_count7", count_o, 7);
        check("t3_not_full", full_o, 0);
        step();
        check("t3_tenth_ack", ack_o, 1);
        check("t3_count_refill", count_o, 8);
        check("t3_full_again", full_o, 1);
        ack_pulse();
        auto_ack = 1'b1;
        wait_idle(500, "t3_drain");
        check("t3_total", ev_x.size() - base, 10);
        for (int i = 0; i < 10; i++)
            if (base + i < ev_x.size()) check($sformatf("t3_order%0d", i), ev_x[base + i], 16'(100 + i));

        // T4 ordering under random renderer latency
        base = ev_x.size();
        late = 0;
        for (int i = 0; i < 20; i++) begin
            send_frag(16'(i), 16'd5, 32'hB0000000 + i, w);
            if (w >= 50) late++;
        end
        check("t4_ack_timeouts", late, 0);
        wait_idle(2000, "t4_drain");
        check("t4_total", ev_x.size() - base, 20);
        for (int i = 0; i < 20; i++)
            if (base + i < ev_x.size()) begin
                check($sformatf("t4_x%0d", i), ev_x[base + i], 16'(i));
                check($sformatf("t4_c%0d", i), ev_c[base + i], 32'hB0000000 + i);
            end

        // T5 asynchronous reset with 5 stored and one in flight
        auto_ack = 1'b0;
        for (int i = 0; i < 6; i++)
            send_frag(16'(200 + i), 16'd7, 32'hC0000000 + i, w);
        check("t5_count_pre", count_o, 5);
        check("t5_x_pre", pixel_x_o, 16'd200);
        rst_i = 1'b1;
        #1;
        check("t5_rst_count", count_o, 0);
        check("t5_rst_write", write_o, 0);
        check("t5_rst_ack", ack_o, 0);
        check("t5_rst_full", full_o, 0);
        check("t5_rst_busy", busy_o, 0);
        check("t5_rst_x", pixel_x_o, 0);
        check("t5_rst_color", color_o, 0);
        step();
        rst_i = 1'b0;
        base = ev_x.size();
        ack_pulse();
        repeat (4) step();
        check("t5_no_write", ev_x.size() - base, 0);
        check("t5_count_after", count_o, 0);

        // T6 pointer wrap over three fill/drain rounds
        auto_ack = 1'b1;
        for (int r = 0; r < 3; r++) begin
            base = ev_x.size();
            for (int i = 0; i < 6; i++)
                send_frag(16'(300 + r * 6 + i), 16'd9, 32'hC0DE0000 + r * 6 + i, w);
            wait_idle(1000, $sformatf("t6_drain%0d", r));
            check($sformatf("t6_total%0d", r), ev_x.size() - base, 6);
            for (int i = 0; i < 6; i++)
                if (base + i < ev_x.size()) begin
                    check($sformatf("t6_x%0d_%0d", r, i), ev_x[base + i], 16'(300 + r * 6 + i));
                    check($sformatf("t6_c%0d_%0d", r, i), ev_c[base + i], 32'hC0DE0000 + r * 6 + i);
                end
        end
        check("t6_count_end", count_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
